// File: rtl/carrier_pkg.sv
// Shared types and constants for the three-phase carrier sequencer.
// The phase offsets describe the ROM's -60 and -120 degree taps.
package carrier_pkg;
    localparam int ACC_WIDTH_DEF  = 32;
    localparam int ADDR_WIDTH_DEF = 16;
    localparam int DATA_WIDTH_DEF = 16;
    localparam int PRE_WIDTH_DEF  = 16;

    localparam int PHASE2_OFFSET = 10923;
    localparam int PHASE3_OFFSET = 21845;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2
    } state_t;
endpackage

// File: rtl/tick_gen.sv
// Prescale counter: asserts tick once every pre+1 enabled cycles.
// The counter is held at zero while disabled or when cleared.
module tick_gen
    import carrier_pkg::*;
#(
    parameter int PRE_WIDTH = PRE_WIDTH_DEF
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 en,
    input  logic                 clr,
    input  logic [PRE_WIDTH-1:0] pre,
    output logic                 tick
);
    logic [PRE_WIDTH-1:0] cnt_q, cnt_d;

    always_comb begin
        tick  = en && (cnt_q == pre);
        cnt_d = cnt_q + 1'b1;
        if (!en || clr || tick) begin
            cnt_d = '0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end
endmodule

// File: rtl/carrier_sequencer.sv
// Phase-accumulator sequencer for the shared three-phase carrier ROM.
// Config and stop requests only take effect at accumulator wrap.
module carrier_sequencer
    import carrier_pkg::*;
#(
    parameter int ACC_WIDTH  = ACC_WIDTH_DEF,
    parameter int ADDR_WIDTH = ADDR_WIDTH_DEF,
    parameter int DATA_WIDTH = DATA_WIDTH_DEF,
    parameter int PRE_WIDTH  = PRE_WIDTH_DEF
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         cfg_valid,
    output logic                         cfg_ready,
    input  logic [ACC_WIDTH-1:0]         cfg_ftw,
    input  logic [PRE_WIDTH-1:0]         cfg_pre,
    input  logic                         start,
    input  logic                         stop,
    output logic [ADDR_WIDTH-1:0]        rom_addr,
    input  logic signed [DATA_WIDTH-1:0] rom_d1,
    input  logic signed [DATA_WIDTH-1:0] rom_d2,
    input  logic signed [DATA_WIDTH-1:0] rom_d3,
    output logic                         smp_valid,
    output logic signed [DATA_WIDTH-1:0] smp1,
    output logic signed [DATA_WIDTH-1:0] smp2,
    output logic signed [DATA_WIDTH-1:0] smp3,
    output logic                         wrap,
    output logic                         busy
);
    state_t                  state_q, state_d;
    logic [ACC_WIDTH-1:0]    acc_q, acc_d;
    logic [ACC_WIDTH-1:0]    ftw_act_q, ftw_act_d;
    logic [PRE_WIDTH-1:0]    pre_act_q, pre_act_d;
    logic                    pend_q, pend_d;
    logic [ACC_WIDTH-1:0]    pend_ftw_q, pend_ftw_d;
    logic [PRE_WIDTH-1:0]    pend_pre_q, pend_pre_d;
    logic                    wrap_q, wrap_d;
    logic                    tick_dly_q, tick_dly_d;
    logic                    smp_valid_q, smp_valid_d;
    logic signed [DATA_WIDTH-1:0] smp1_q, smp1_d, smp2_q, smp2_d, smp3_q, smp3_d;

    logic                    tick;
    logic                    running;
    logic                    carry_tick;
    logic                    apply;
    logic [ACC_WIDTH:0]      sum;

    assign running = (state_q != IDLE);

    tick_gen #(.PRE_WIDTH(PRE_WIDTH)) u_tick_gen (
        .clk   (clk),
        .rst_n (rst_n),
        .en    (running),
        .clr   (apply),
        .pre   (pre_act_q),
        .tick  (tick)
    );

    always_comb begin
        sum        = {1'b0, acc_q} + {1'b0, ftw_act_q};
        carry_tick = tick && sum[ACC_WIDTH];
        apply      = pend_q && (!running || carry_tick);

        state_d     = state_q;
        acc_d       = acc_q;
        ftw_act_d   = ftw_act_q;
        pre_act_d   = pre_act_q;
        pend_d      = pend_q;
        pend_ftw_d  = pend_ftw_q;
        pend_pre_d  = pend_pre_q;
        wrap_d      = carry_tick;
        tick_dly_d  = tick;
        smp_valid_d = tick_dly_q;
        smp1_d      = smp1_q;
        smp2_d      = smp2_q;
        smp3_d      = smp3_q;

        // A slot can only be accepted while empty, so apply and accept never coincide.
        if (apply) begin
            ftw_act_d = pend_ftw_q;
            pre_act_d = pend_pre_q;
            pend_d    = 1'b0;
        end else if (cfg_valid && !pend_q) begin
            pend_d     = 1'b1;
            pend_ftw_d = cfg_ftw;
            pend_pre_d = cfg_pre;
        end

        if (tick) begin
            acc_d = sum[ACC_WIDTH-1:0];
        end

        // ROM words are combinational from the address, which moved on the previous tick.
        if (tick_dly_q) begin
            smp1_d = rom_d1;
            smp2_d = rom_d2;
            smp3_d = rom_d3;
        end

        case (state_q)
            IDLE: begin
                acc_d = '0;
                if (start) begin
                    state_d = RUN;
                end
            end
            RUN: begin
                if (stop) begin
                    state_d = DRAIN;
                end
            end
            DRAIN: begin
                if (carry_tick) begin
                    state_d = IDLE;
                    acc_d   = '0;
                end else if (ftw_act_q == '0) begin
                    state_d = IDLE;
                end else if (start && !stop) begin
                    state_d = RUN;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            acc_q       <= '0;
            ftw_act_q   <= '0;
            pre_act_q   <= '0;
            pend_q      <= 1'b0;
            pend_ftw_q  <= '0;
            pend_pre_q  <= '0;
            wrap_q      <= 1'b0;
            tick_dly_q  <= 1'b0;
            smp_valid_q <= 1'b0;
            smp1_q      <= '0;
            smp2_q      <= '0;
            smp3_q      <= '0;
        end else begin
            state_q     <= state_d;
            acc_q       <= acc_d;
            ftw_act_q   <= ftw_act_d;
            pre_act_q   <= pre_act_d;
            pend_q      <= pend_d;
            pend_ftw_q  <= pend_ftw_d;
            pend_pre_q  <= pend_pre_d;
            wrap_q      <= wrap_d;
            tick_dly_q  <= tick_dly_d;
            smp_valid_q <= smp_valid_d;
            smp1_q      <= smp1_d;
            smp2_q      <= smp2_d;
            smp3_q      <= smp3_d;
        end
    end

    assign rom_addr  = acc_q[ACC_WIDTH-1 -: ADDR_WIDTH];
    assign cfg_ready = !pend_q;
    assign busy      = running;
    assign wrap      = wrap_q;
    assign smp_valid = smp_valid_q;
    assign smp1      = smp1_q;
    assign smp2      = smp2_q;
    assign smp3      = smp3_q;
endmodule

// File: tb/tb_carrier_sequencer.sv
// Directed bench for carrier_sequencer with a behavioural three-phase ROM.
module tb_carrier_sequencer;
    import carrier_pkg::*;

    logic               clk = 1'b0;
    logic               rst_n = 1'b0;
    logic               cfg_valid = 1'b0;
    logic               cfg_ready;
    logic [31:0]        cfg_ftw = '0;
    logic [15:0]        cfg_pre = '0;
    logic               start = 1'b0;
    logic               stop = 1'b0;
    logic [15:0]        rom_addr;
    logic signed [15:0] rom_d1, rom_d2, rom_d3;
    logic               smp_valid;
    logic signed [15:0] smp1, smp2, smp3;
    logic               wrap;
    logic               busy;

    int compared   = 0;
    int mismatched = 0;

    always #5 clk = ~clk;

    function automatic logic signed [15:0] rom_f(input logic [15:0] a);
        return {a[7:0], a[15:8]} ^ 16'h1234;
    endfunction

    function automatic logic [15:0] ph(input logic [15:0] a, input int off);
        return 16'(a - 16'(off));
    endfunction

    assign rom_d1 = rom_f(rom_addr);
    assign rom_d2 = rom_f(ph(rom_addr, PHASE2_OFFSET));
    assign rom_d3 = rom_f(ph(rom_addr, PHASE3_OFFSET));

    carrier_sequencer dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .cfg_valid (cfg_valid),
        .cfg_ready (cfg_ready),
        .cfg_ftw   (cfg_ftw),
        .cfg_pre   (cfg_pre),
        .start     (start),
        .stop      (stop),
        .rom_addr  (rom_addr),
        .rom_d1    (rom_d1),
        .rom_d2    (rom_d2),
        .rom_d3    (rom_d3),
        .smp_valid (smp_valid),
        .smp1      (smp1),
        .smp2      (smp2),
        .smp3      (smp3),
        .wrap      (wrap),
        .busy      (busy)
    );

    task automatic step;
        @(posedge clk);
        #1;
    endtask

    task automatic do_cfg(input logic [31:0] ftw, input logic [15:0] pre);
        cfg_ftw   = ftw;
        cfg_pre   = pre;
        cfg_valid = 1'b1;
        step();
        cfg_valid = 1'b0;
        step();
    endtask

    task automatic apply_reset;
        start     = 1'b0;
        stop      = 1'b0;
        cfg_valid = 1'b0;
        rst_n     = 1'b0;
        #2;
        rst_n     = 1'b1;
    endtask

    task automatic test_reset;
        rst_n = 1'b0;
        for (int i = 0; i < 5; i++) begin
            cfg_valid = 1'($urandom);
            cfg_ftw   = $urandom;
            cfg_pre   = 16'($urandom);
            start     = 1'($urandom);
            stop      = 1'($urandom);
            step();
            compared++;
            if ({rom_addr, smp_valid, smp1, smp2, smp3, wrap, busy, cfg_ready} !==
                {16'h0, 1'b0, 16'h0, 16'h0, 16'h0, 1'b0, 1'b0, 1'b1}) begin
                mismatched++;
                $display("FAIL reset_state i=%0d got addr=%h v=%b s=%h/%h/%h wrap=%b busy=%b rdy=%b want zeros rdy=1",
                         i, rom_addr, smp_valid, smp1, smp2, smp3, wrap, busy, cfg_ready);
            end
        end
        cfg_valid = 1'b0;
        start     = 1'b0;
        stop      = 1'b0;
        rst_n     = 1'b1;
        step();
        $display("test_reset done");
    endtask

    task automatic test_basic_step;
        logic [15:0] a;
        do_cfg(32'h0001_0000, 16'd0);
        start = 1'b1;
        step();
        start = 1'b0;
        compared++;
        if ({busy, rom_addr} !== {1'b1, 16'h0}) begin
            mismatched++;
            $display("FAIL step_start got busy=%b addr=%h want busy=1 addr=0000", busy, rom_addr);
        end
        for (int k = 1; k <= 8; k++) begin
            step();
            compared++;
            if (rom_addr !== 16'(k)) begin
                mismatched++;
                $display("FAIL step_addr k=%0d got %h want %h", k, rom_addr, 16'(k));
            end
            compared++;
            if (smp_valid !== (k >= 2)) begin
                mismatched++;
                $display("FAIL step_valid k=%0d got %b want %b", k, smp_valid, (k >= 2));
            end
            if (k >= 2) begin
                a = 16'(k - 1);
                compared++;
                if ({smp1, smp2, smp3} !== {rom_f(a), rom_f(ph(a, PHASE2_OFFSET)), rom_f(ph(a, PHASE3_OFFSET))}) begin
                    mismatched++;
                    $display("FAIL step_samples k=%0d got %h/%h/%h want %h/%h/%h", k, smp1, smp2, smp3,
                             rom_f(a), rom_f(ph(a, PHASE2_OFFSET)), rom_f(ph(a, PHASE3_OFFSET)));
                end
            end
        end
        apply_reset();
        $display("test_basic_step done");
    endtask

    task automatic test_wrap;
        do_cfg(32'h4000_0000, 16'd0);
        start = 1'b1;
        step();
        start = 1'b0;
        for (int k = 1; k <= 8; k++) begin
            step();
            compared++;
            if ({rom_addr, wrap} !== {16'(k * 16'h4000), (k % 4 == 0)}) begin
                mismatched++;
                $display("FAIL wrap_seq k=%0d got addr=%h wrap=%b want addr=%h wrap=%b",
                         k, rom_addr, wrap, 16'(k * 16'h4000), (k % 4 == 0));
            end
        end
        $display("test_wrap done");
    endtask

    task automatic test_live_reconfig;
        logic [15:0] exp_a [7] = '{16'h4000, 16'h8000, 16'hC000, 16'h0000, 16'h8000, 16'h0000, 16'h8000};
        logic        exp_r [7] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1};
        logic        exp_w [7] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0};
        cfg_ftw   = 32'h8000_0000;
        cfg_pre   = 16'd0;
        cfg_valid = 1'b1;
        compared++;
        if (cfg_ready !== 1'b1) begin
            mismatched++;
            $display("FAIL reconfig_ready_before got %b want 1", cfg_ready);
        end
        for (int i = 0; i < 7; i++) begin
            step();
            cfg_valid = 1'b0;
            compared++;
            if ({rom_addr, cfg_ready, wrap} !== {exp_a[i], exp_r[i], exp_w[i]}) begin
                mismatched++;
                $display("FAIL reconfig_seq i=%0d got addr=%h rdy=%b wrap=%b want addr=%h rdy=%b wrap=%b",
                         i, rom_addr, cfg_ready, wrap, exp_a[i], exp_r[i], exp_w[i]);
            end
        end
        apply_reset();
        $display("test_live_reconfig done");
    endtask

    task automatic test_stop_drain;
        logic [15:0] exp_a [5] = '{16'h8000, 16'hC000, 16'h0000, 16'h0000, 16'h0000};
        logic        exp_b [5] = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b0};
        logic        exp_w [5] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
        logic        exp_v [5] = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0};
        logic [15:0] exp_s [5] = '{16'h4000, 16'h8000, 16'hC000, 16'h0000, 16'h0000};
        // Drain with a zero tuning word must fall back to idle without a wrap.
        start = 1'b1;
        step();
        start = 1'b0;
        stop  = 1'b1;
        step();
        stop  = 1'b0;
        compared++;
        if (busy !== 1'b1) begin
            mismatched++;
            $display("FAIL drain_zero_ftw_busy got %b want 1", busy);
        end
        step();
        compared++;
        if (busy !== 1'b0) begin
            mismatched++;
            $display("FAIL drain_zero_ftw_idle got %b want 0", busy);
        end

        do_cfg(32'h4000_0000, 16'd0);
        start = 1'b1;
        step();
        start = 1'b0;
        step();
        stop = 1'b1;
        for (int i = 0; i < 5; i++) begin
            step();
            stop = 1'b0;
            compared++;
            if ({rom_addr, busy, wrap, smp_valid} !== {exp_a[i], exp_b[i], exp_w[i], exp_v[i]}) begin
                mismatched++;
                $display("FAIL drain_seq i=%0d got addr=%h busy=%b wrap=%b v=%b want addr=%h busy=%b wrap=%b v=%b",
                         i, rom_addr, busy, wrap, smp_valid, exp_a[i], exp_b[i], exp_w[i], exp_v[i]);
            end
            if (exp_v[i]) begin
                compared++;
                if (smp1 !== rom_f(exp_s[i])) begin
                    mismatched++;
                    $display("FAIL drain_smp1 i=%0d got %h want %h", i, smp1, rom_f(exp_s[i]));
                end
            end
        end

        // start and stop together: first edge starts, second edge in RUN drains.
        start = 1'b1;
        stop  = 1'b1;
        step();
        step();
        start = 1'b0;
        stop  = 1'b0;
        step();
        step();
        compared++;
        if ({rom_addr, busy} !== {16'hC000, 1'b1}) begin
            mismatched++;
            $display("FAIL start_stop_pre_wrap got addr=%h busy=%b want addr=c000 busy=1", rom_addr, busy);
        end
        step();
        compared++;
        if ({rom_addr, busy, wrap} !== {16'h0000, 1'b0, 1'b1}) begin
            mismatched++;
            $display("FAIL start_stop_drained got addr=%h busy=%b wrap=%b want addr=0000 busy=0 wrap=1",
                     rom_addr, busy, wrap);
        end

        // A start while draining cancels the stop.
        start = 1'b1;
        step();
        start = 1'b0;
        stop  = 1'b1;
        step();
        stop  = 1'b0;
        start = 1'b1;
        step();
        start = 1'b0;
        step();
        step();
        compared++;
        if ({rom_addr, busy, wrap} !== {16'h0000, 1'b1, 1'b1}) begin
            mismatched++;
            $display("FAIL drain_cancel_wrap got addr=%h busy=%b wrap=%b want addr=0000 busy=1 wrap=1",
                     rom_addr, busy, wrap);
        end
        step();
        compared++;
        if ({rom_addr, busy} !== {16'h4000, 1'b1}) begin
            mismatched++;
            $display("FAIL drain_cancel_run got addr=%h busy=%b want addr=4000 busy=1", rom_addr, busy);
        end
        apply_reset();
        $display("test_stop_drain done");
    endtask

    task automatic test_prescale_reset;
        do_cfg(32'h0001_0000, 16'd2);
        start = 1'b1;
        step();
        start = 1'b0;
        for (int k = 1; k <= 10; k++) begin
            step();
            compared++;
            if ({rom_addr, smp_valid} !== {16'(k / 3), (k >= 4 && k % 3 == 1)}) begin
                mismatched++;
                $display("FAIL prescale_seq k=%0d got addr=%h v=%b want addr=%h v=%b",
                         k, rom_addr, smp_valid, 16'(k / 3), (k >= 4 && k % 3 == 1));
            end
        end
        cfg_ftw   = 32'h4000_0000;
        cfg_pre   = 16'd0;
        cfg_valid = 1'b1;
        step();
        cfg_valid = 1'b0;
        compared++;
        if (cfg_ready !== 1'b0) begin
            mismatched++;
            $display("FAIL prescale_pending_ready got %b want 0", cfg_ready);
        end
        rst_n = 1'b0;
        #2;
        compared++;
        if ({rom_addr, smp_valid, smp1, smp2, smp3, wrap, busy, cfg_ready} !==
            {16'h0, 1'b0, 16'h0, 16'h0, 16'h0, 1'b0, 1'b0, 1'b1}) begin
            mismatched++;
            $display("FAIL async_reset got addr=%h v=%b s=%h/%h/%h wrap=%b busy=%b rdy=%b want zeros rdy=1",
                     rom_addr, smp_valid, smp1, smp2, smp3, wrap, busy, cfg_ready);
        end
        rst_n = 1'b1;
        // Discarded pending config means a bare start leaves the address parked.
        start = 1'b1;
        step();
        start = 1'b0;
        step();
        step();
        compared++;
        if ({rom_addr, busy} !== {16'h0000, 1'b1}) begin
            mismatched++;
            $display("FAIL pending_discarded got addr=%h busy=%b want addr=0000 busy=1", rom_addr, busy);
        end
        stop = 1'b1;
        step();
        stop = 1'b0;
        step();
        do_cfg(32'h0001_0000, 16'd0);
        start = 1'b1;
        step();
        start = 1'b0;
        compared++;
        if ({rom_addr, busy} !== {16'h0000, 1'b1}) begin
            mismatched++;
            $display("FAIL restart_e0 got addr=%h busy=%b want addr=0000 busy=1", rom_addr, busy);
        end
        step();
        compared++;
        if (rom_addr !== 16'h0001) begin
            mismatched++;
            $display("FAIL restart_e1 got %h want 0001", rom_addr);
        end
        apply_reset();
        $display("test_prescale_reset done");
    endtask

    initial begin
        test_reset();
        test_basic_step();
        test_wrap();
        test_live_reconfig();
        test_stop_drain();
        test_prescale_reset();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end
endmodule

// File: doc/carrier_sequencer.md
# carrier_sequencer

Phase-accumulator controller that sequences the shared three-phase carrier ROM. It drives the ROM's 16-bit address from a 32-bit accumulator stepped by a programmable frequency tuning word at a prescaled rate, then registers the three phase-shifted ROM words with a valid strobe for the PWM comparators. Configuration updates and stop requests take effect only at carrier wrap, so every carrier period completes cleanly.

## Interface
- ACC_WIDTH, 32, phase accumulator width
- ADDR_WIDTH, 16, ROM address width; `rom_addr` = `acc[ACC_WIDTH-1 -: ADDR_WIDTH]`
- DATA_WIDTH, 16, signed ROM word width
- PRE_WIDTH, 16, prescaler width

Ports:
- clk  in  1  system clock, rising edge
- rst_n  in  1  asynchronous active-low reset
- cfg_valid  in  1  config offer
- cfg_ready  out  1  config slot free
- cfg_ftw  in  ACC_WIDTH  tuning word, unsigned
- cfg_pre  in  PRE_WIDTH  accumulator steps once every cfg_pre+1 cycles
- start  in  1  run request, level sampled
- stop  in  1  stop-at-wrap request, level sampled
- rom_addr  out  ADDR_WIDTH  ROM address, registered
- rom_d1, rom_d2, rom_d3  in  DATA_WIDTH signed  combinational ROM outputs (0°, −60°, −120°)
- smp_valid  out  1  one-cycle strobe, smp1..3 updated
- smp1, smp2, smp3  out  DATA_WIDTH signed  registered carrier samples
- wrap  out  1  one-cycle pulse on accumulator carry-out
- busy  out  1  state ≠ IDLE

## Operation
- States:
  - IDLE: acc = 0, prescale counter = 0, no ticks.
  - RUN: free-running.
  - DRAIN: running, will stop at the next wrap.
- Transitions:
  - IDLE + start → RUN.
  - RUN + stop → DRAIN. stop wins when start and stop are asserted together.
  - DRAIN + start (stop low) → RUN, cancelling the stop.
  - DRAIN + wrap → IDLE; acc cleared on that edge.
  - DRAIN with active ftw == 0 → IDLE on the next edge.
- Tick:
  - In RUN or DRAIN, tick = (cnt == pre_active).
  - On a tick, cnt ← 0; otherwise cnt ← cnt+1.
  - On a tick, {carry, acc} ← acc + ftw_active. Modulo 2^ACC_WIDTH; carry is the wrap indication.
- Config:
  - Handshake is cfg_valid & cfg_ready. One pending register; cfg_ready = !pending.
  - In IDLE, the pending config is copied to ftw_active/pre_active on the next edge.
  - In RUN or DRAIN, the pending config is copied on the wrap edge and used from the following tick. cnt is cleared on that edge.
- Sampling: smp1..3 ← rom_d1..3 and smp_valid = 1 on the cycle after every tick. The captured words correspond to the new rom_addr.
- Reset values: rom_addr = 0, smp1..3 = 0, smp_valid = 0, wrap = 0, busy = 0, cfg_ready = 1. Internally: acc = 0, ftw_active = 0, pre_active = 0, pending = 0, state IDLE.

## Timing
- start sampled at edge E0 → busy = 1 after E0.
- With pre = 0: first tick at E1 (rom_addr updates after E1); first smp_valid after E2.
- Address-to-sample latency: 1 cycle. Tick-to-smp_valid: 1 cycle.
- wrap is registered and asserted during the same cycle as the rom_addr that results from the carrying tick.
- Prescale n: ticks spaced exactly n+1 cycles apart.
- Async reset mid-operation: all outputs go to reset values immediately. Pending config is discarded.
- Simultaneous cfg handshake and wrap edge: the old pending config, if any, is applied; the new one is latched as pending. With nothing pending, the new config is latched and waits for the next wrap.

## Structure
- Package carrier_pkg: state enum (IDLE, RUN, DRAIN), default widths, ROM phase offsets 10923/21845 as named constants for the bench model.
- Sub-module tick_gen: prescale counter with clear input, producing the tick.
- Everything else lives in the top module.

## Test plan
- Reset: hold rst_n low with random inputs → all outputs 0, cfg_ready = 1, busy = 0.
- Basic step: cfg ftw = 0x0001_0000, pre = 0, then start → rom_addr 1, 2, 3… each cycle. smp_valid continuous from the second cycle after start; smp1..3 match the ROM model at addr, addr−10923, addr−21845 (mod 2^16).
- Wrap: ftw = 0x4000_0000, pre = 0 → rom_addr 0x4000, 0x8000, 0xC000, 0x0000. wrap high only with 0x0000; repeats every 4 cycles.
- Live reconfig: in RUN with ftw 0x4000_0000, offer ftw 0x8000_0000 → cfg_ready low until the wrap. Steps after the wrap become 0x8000 (rom_addr 0x8000, 0x0000, …).
- Stop/drain: stop at rom_addr 0x4000 → continues through 0x8000 and 0xC000, enters IDLE at the wrap (rom_addr 0, busy 0). start and stop together in RUN → DRAIN.
- Prescale and reset: pre = 2 → smp_valid every 3 cycles. Assert rst_n low mid-period → outputs 0 immediately; restart begins from rom_addr 0.
